// File: rtl/ir_tx_cmd_queue.sv
// ir_tx_cmd_queue: queues NEC {address, command} requests and feeds them one frame at a time to the IR transmitter.
// Define IR_CMDQ_STATS_EN to add the oFRAME_CNT / oDROP_CNT statistics ports.
`timescale 1ns/1ps

// Generic register FIFO with synchronous flush and occupancy count.
// Latency: a write is visible at the head one cycle after its edge; read data is combinational.
// Backpressure: writes when full and reads when empty are ignored; callers gate on full/empty.
module ir_cmdq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrEn,
  input  logic [W-1:0]               wrDat,
  input  logic                       rdEn,
  input  logic                       flush,
  output logic [W-1:0]               rdDat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          wrOk;
  logic          rdOk;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wrOk  = wrEn & ~full;
  assign rdOk  = rdEn & ~empty;
  assign rdDat = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPtr] <= wrDat;
  end

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + 1'b1;
      if (rdOk) rdPtr <= rdPtr + 1'b1;
      level <= level + LW'(wrOk) - LW'(rdOk);
    end
  end
endmodule

// NEC request queue and send sequencer.
// Latency: write at edge k on an idle queue -> oSEND high after edge k+2 for one cycle.
// Backpressure: oWR_READY low when full or flushing; a write while full is dropped and flagged on oOVERFLOW.
module ir_tx_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   iCLK_50,
  input  logic                   iRST,
  input  logic                   iWR_VALID,
  input  logic [7:0]             iWR_ADDR,
  input  logic [7:0]             iWR_CMD,
  output logic                   oWR_READY,
  input  logic                   iFLUSH,
  input  logic                   iTX_BUSY,
  output logic [7:0]             oADDRESS,
  output logic [7:0]             oCOMMAND,
  output logic                   oSEND,
  output logic [$clog2(DEPTH):0] oLEVEL,
  output logic                   oEMPTY,
  output logic                   oOVERFLOW,
  output logic                   oIDLE
`ifdef IR_CMDQ_STATS_EN
  ,
  output logic [15:0]            oFRAME_CNT,
  output logic [15:0]            oDROP_CNT
`endif
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] ackTimer;
  logic          full;
  logic          wrEn;
  logic          popEn;
  logic [15:0]   headDat;

  assign oWR_READY = ~full & ~iFLUSH;
  assign wrEn      = iWR_VALID & oWR_READY;
  assign popEn     = (state == S_LOAD) & ~oEMPTY;
  assign oIDLE     = (state == S_IDLE) & oEMPTY;

  ir_cmdq_fifo #(
    .W     (16),
    .DEPTH (DEPTH)
  ) cmdFifo (
    .clk   (iCLK_50),
    .rst   (iRST),
    .wrEn  (wrEn),
    .wrDat ({iWR_ADDR, iWR_CMD}),
    .rdEn  (popEn),
    .flush (iFLUSH),
    .rdDat (headDat),
    .level (oLEVEL),
    .full  (full),
    .empty (oEMPTY)
  );

  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) oOVERFLOW <= 1'b0;
    else      oOVERFLOW <= iWR_VALID & full;
  end

  // oSEND is raised on every entry into S_SEND so it is high exactly while in S_SEND.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state    <= S_IDLE;
      oSEND    <= 1'b0;
      oADDRESS <= 8'h00;
      oCOMMAND <= 8'h00;
      ackTimer <= '0;
    end else begin
      oSEND <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!oEMPTY && !iTX_BUSY) state <= S_LOAD;
        end
        S_LOAD: begin
          // A flush landing on the IDLE->LOAD edge leaves nothing to pop.
          if (oEMPTY) begin
            state <= S_IDLE;
          end else begin
            {oADDRESS, oCOMMAND} <= headDat;
            ackTimer             <= '0;
            oSEND                <= 1'b1;
            state                <= S_SEND;
          end
        end
        S_SEND: begin
          ackTimer <= '0;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (iTX_BUSY) begin
            state <= S_WAIT_DONE;
          end else if (ackTimer == TW'(ACK_TIMEOUT - 1)) begin
            ackTimer <= '0;
            oSEND    <= 1'b1;
            state    <= S_SEND;
          end else begin
            ackTimer <= ackTimer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!iTX_BUSY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IR_CMDQ_STATS_EN
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      oFRAME_CNT <= 16'h0000;
      oDROP_CNT  <= 16'h0000;
    end else begin
      if (state == S_WAIT_DONE && !iTX_BUSY) oFRAME_CNT <= oFRAME_CNT + 16'd1;
      if (iWR_VALID && full)                 oDROP_CNT  <= oDROP_CNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ir_tx_cmd_queue.sv
// Scoreboard bench for ir_tx_cmd_queue: queued requests are compared against every oSEND strobe.
`timescale 1ns/1ps

module tb_ir_tx_cmd_queue;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 16;

  logic       iCLK_50   = 1'b0;
  logic       iRST      = 1'b1;
  logic       iWR_VALID = 1'b0;
  logic [7:0] iWR_ADDR  = 8'h00;
  logic [7:0] iWR_CMD   = 8'h00;
  logic       iFLUSH    = 1'b0;
  logic       iTX_BUSY;
  logic       oWR_READY;
  logic [7:0] oADDRESS;
  logic [7:0] oCOMMAND;
  logic       oSEND;
  logic [$clog2(DEPTH):0] oLEVEL;
  logic       oEMPTY;
  logic       oOVERFLOW;
  logic       oIDLE;
`ifdef IR_CMDQ_STATS_EN
  logic [15:0] oFRAME_CNT;
  logic [15:0] oDROP_CNT;
`endif

  logic busyExt   = 1'b0;
  logic busyModel = 1'b0;
  logic modelEn   = 1'b0;
  logic armed     = 1'b0;
  int   busyLen   = 100;
  int   busyCnt   = 0;

  int errCnt  = 0;
  int chkCnt  = 0;
  int cyc     = 0;
  int sendCnt = 0;
  int ovfCnt  = 0;
  int sendCyc[$];
  logic [15:0] expQ[$];
  logic [15:0] cur       = 16'h0000;
  logic        haveCur   = 1'b0;
  logic        retryMode = 1'b0;

  assign iTX_BUSY = busyExt | busyModel;

  ir_tx_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .iCLK_50   (iCLK_50),
    .iRST      (iRST),
    .iWR_VALID (iWR_VALID),
    .iWR_ADDR  (iWR_ADDR),
    .iWR_CMD   (iWR_CMD),
    .oWR_READY (oWR_READY),
    .iFLUSH    (iFLUSH),
    .iTX_BUSY  (iTX_BUSY),
    .oADDRESS  (oADDRESS),
    .oCOMMAND  (oCOMMAND),
    .oSEND     (oSEND),
    .oLEVEL    (oLEVEL),
    .oEMPTY    (oEMPTY),
    .oOVERFLOW (oOVERFLOW),
    .oIDLE     (oIDLE)
`ifdef IR_CMDQ_STATS_EN
    ,
    .oFRAME_CNT(oFRAME_CNT),
    .oDROP_CNT (oDROP_CNT)
`endif
  );

  always #10 iCLK_50 = ~iCLK_50;
  always @(posedge iCLK_50) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy rises one cycle after a strobe and holds for busyLen cycles.
  always @(negedge iCLK_50) begin
    if (!modelEn) begin
      armed     = 1'b0;
      busyModel = 1'b0;
      busyCnt   = 0;
    end else begin
      if (armed) begin
        armed     = 1'b0;
        busyModel = 1'b1;
        busyCnt   = busyLen;
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) busyModel = 1'b0;
      end
      if (oSEND && !busyModel) armed = 1'b1;
    end
  end

  // Scoreboard: each new frame pops an expected entry; retries must repeat the current one.
  always @(negedge iCLK_50) begin
    if (!retryMode) haveCur = 1'b0;
    if (oOVERFLOW) ovfCnt++;
    if (oSEND) begin
      sendCnt++;
      sendCyc.push_back(cyc);
      if (!(retryMode && haveCur)) begin
        if (expQ.size() == 0) begin
          checkVal("spurious_send", 32'd1, 32'd0);
          cur = 16'h0000;
        end else begin
          cur = expQ.pop_front();
        end
        haveCur = retryMode;
      end
      checkVal("send_data", {oADDRESS, oCOMMAND}, cur);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge iCLK_50);
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] c, input logic expAcc, input string tag);
    iWR_VALID = 1'b1;
    iWR_ADDR  = a;
    iWR_CMD   = c;
    #1;
    checkVal(tag, oWR_READY, expAcc);
    if (expAcc) expQ.push_back({a, c});
    @(negedge iCLK_50);
    iWR_VALID = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, input string tag);
    int n = 0;
    while (!oIDLE && n < maxCyc) begin
      @(negedge iCLK_50);
      n++;
    end
    checkVal(tag, oIDLE, 1);
  endtask

  task automatic waitBusyModel(input int maxCyc, input string tag);
    int n = 0;
    while (!busyModel && n < maxCyc) begin
      @(negedge iCLK_50);
      n++;
    end
    checkVal(tag, busyModel, 1);
  endtask

  task automatic checkReset(input string p);
    checkVal({p, "level"},    oLEVEL,    0);
    checkVal({p, "empty"},    oEMPTY,    1);
    checkVal({p, "ready"},    oWR_READY, 1);
    checkVal({p, "send"},     oSEND,     0);
    checkVal({p, "overflow"}, oOVERFLOW, 0);
    checkVal({p, "addr"},     oADDRESS,  0);
    checkVal({p, "cmd"},      oCOMMAND,  0);
    checkVal({p, "idle"},     oIDLE,     1);
`ifdef IR_CMDQ_STATS_EN
    checkVal({p, "frame_cnt"}, oFRAME_CNT, 0);
    checkVal({p, "drop_cnt"},  oDROP_CNT,  0);
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    int o0;
    int n0;

    repeat (3) @(negedge iCLK_50);
    checkReset("rst_");
    iRST = 1'b0;
    @(negedge iCLK_50);

    // Single request with a well-behaved transmitter
    busyLen = 100;
    modelEn = 1'b1;
    s0 = sendCnt;
    doWrite(8'h12, 8'h34, 1'b1, "t1_ready");
    checkVal("t1_empty_k", oEMPTY, 0);
    checkVal("t1_level_k", oLEVEL, 1);
    checkVal("t1_send_k",  oSEND,  0);
    @(negedge iCLK_50);
    checkVal("t1_send_k1", oSEND, 0);
    @(negedge iCLK_50);
    checkVal("t1_send_k2", oSEND,    1);
    checkVal("t1_addr",    oADDRESS, 8'h12);
    checkVal("t1_cmd",     oCOMMAND, 8'h34);
    waitIdle(300, "t1_idle");
    checkVal("t1_strobes", sendCnt - s0, 1);

    // Burst into a full queue while another master holds the transmitter
    modelEn = 1'b0;
    busyExt = 1'b1;
    @(negedge iCLK_50);
`ifdef IR_CMDQ_STATS_EN
    force dut.oFRAME_CNT = 16'hFFFF;
    force dut.oDROP_CNT  = 16'hFFFF;
    @(negedge iCLK_50);
    release dut.oFRAME_CNT;
    release dut.oDROP_CNT;
`endif
    o0 = ovfCnt;
    s0 = sendCnt;
    for (int i = 0; i < 6; i++) doWrite(8'h40 + 8'(i), 8'hA0 + 8'(i), (i < DEPTH), "t2_ready");
    @(negedge iCLK_50);
    checkVal("t2_ovf_pulses", ovfCnt - o0, 2);
    checkVal("t2_ovf_low",    oOVERFLOW,   0);
    checkVal("t2_level",      oLEVEL,      4);
    checkVal("t2_ready_full", oWR_READY,   0);
    checkVal("t2_no_send",    sendCnt - s0, 0);
`ifdef IR_CMDQ_STATS_EN
    checkVal("t2_drop_wrap",  oDROP_CNT,  16'h0001);
    checkVal("t2_frame_hold", oFRAME_CNT, 16'hFFFF);
`endif
    busyLen = 20;
    modelEn = 1'b1;
    busyExt = 1'b0;
    @(negedge iCLK_50);
    waitIdle(400, "t2_idle");
    checkVal("t2_strobes",   sendCnt - s0, 4);
    checkVal("t2_q_drained", expQ.size(),  0);
`ifdef IR_CMDQ_STATS_EN
    checkVal("t2_frame_wrap", oFRAME_CNT, 16'h0003);
`endif

    // Transmitter never acknowledges: strobe repeats with the same data
    modelEn   = 1'b0;
    retryMode = 1'b1;
    s0 = sendCnt;
    n0 = sendCyc.size();
    doWrite(8'h5A, 8'hC3, 1'b1, "t3_ready");
    for (int n = 0; n < 100 && (sendCnt - s0) < 3; n++) @(negedge iCLK_50);
    checkVal("t3_three_strobes", ((sendCnt - s0) >= 3), 1);
    if (sendCyc.size() >= n0 + 3) begin
      checkVal("t3_gap1", sendCyc[n0 + 1] - sendCyc[n0],     ACK_TIMEOUT + 1);
      checkVal("t3_gap2", sendCyc[n0 + 2] - sendCyc[n0 + 1], ACK_TIMEOUT + 1);
    end
    busyExt = 1'b1;
    waitCycles(3);
    s1 = sendCnt;
    waitCycles(40);
    checkVal("t3_no_retry", sendCnt - s1, 0);
    busyExt = 1'b0;
    waitIdle(20, "t3_idle");
    retryMode = 1'b0;

    // Flush with one frame in flight and three queued
    busyLen = 100;
    modelEn = 1'b1;
    s0 = sendCnt;
    for (int i = 0; i < 4; i++) doWrite(8'h70 + 8'(i), 8'hB0 + 8'(i), 1'b1, "t4_ready");
    waitBusyModel(20, "t4_busy");
    waitCycles(2);
    checkVal("t4_level_pre", oLEVEL, 3);
    iFLUSH    = 1'b1;
    iWR_VALID = 1'b1;
    iWR_ADDR  = 8'hEE;
    iWR_CMD   = 8'hEE;
    #1;
    checkVal("t4_ready_flush", oWR_READY, 0);
    @(negedge iCLK_50);
    iFLUSH    = 1'b0;
    iWR_VALID = 1'b0;
    expQ.delete();
    checkVal("t4_level", oLEVEL, 0);
    checkVal("t4_empty", oEMPTY, 1);
    waitIdle(200, "t4_idle");
    waitCycles(30);
    checkVal("t4_strobes", sendCnt - s0, 1);

    // Reset during S_WAIT_DONE with two entries queued
    s0 = sendCnt;
    for (int i = 0; i < 3; i++) doWrite(8'h90 + 8'(i), 8'hD0 + 8'(i), 1'b1, "t5_ready");
    waitBusyModel(20, "t5_busy");
    waitCycles(3);
    checkVal("t5_level_pre", oLEVEL, 2);
    iRST = 1'b1;
    #1;
    checkReset("t5_rst_");
    expQ.delete();
    modelEn = 1'b0;
    waitCycles(2);
    iRST = 1'b0;
    waitCycles(40);
    checkVal("t5_no_send", sendCnt - s0, 1);
    busyLen = 10;
    modelEn = 1'b1;
    doWrite(8'hAB, 8'hCD, 1'b1, "t5_ready_new");
    waitIdle(100, "t5_idle");
    checkVal("t5_new_send", sendCnt - s0, 2);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
